otter_fetch_unit: RTL and testbench
===================================

Name: otter_fetch_unit

Overview:
- Instruction-fetch front end of the pipelined OTTER, directly upstream of the IF/DE pipeline register.
- Owns the PC and drives the instruction port of Memory (MEM_ADDR1/MEM_RDEN1, 1-cycle synchronous read).
- Buffers returned instructions in a small queue, so decode can stall without losing fetches.
- Handles redirects (branch/jump) by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, fetch-queue entries (power of 2, ≥2; 2 sustains 1 instr/cycle).

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- STALL  in  1  decode not accepting this cycle; head entry held
- REDIRECT  in  1  redirect fetch stream to REDIRECT_PC (from execute)
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored
- MEM_ADDR1  out  14  word address to Memory instruction port (pc[15:2])
- MEM_RDEN1  out  1  instruction read enable (issue strobe)
- MEM_DOUT1  in  32  instruction data, valid the cycle after issue
- IF_VALID  out  1  IF_IR/IF_PC hold a valid instruction
- IF_IR  out  32  instruction at queue head
- IF_PC  out  32  address of IF_IR
- IF_PC_INC  out  32  IF_PC + 4

Behaviour:
- Clock is CLK; reset is RST, asynchronous and active-high.
- Reset (async) values:
  - pc = RESET_PC; queue count = 0; in-flight = 0; IF_VALID = 0.
  - IF_IR = 32'h0000_0013 (NOP); IF_PC = RESET_PC; IF_PC_INC = RESET_PC+4.
  - MEM_RDEN1 = 0.
- Reset mid-operation: all state clears immediately; a response arriving after reset is discarded (in-flight = 0).
- Issue rule (cycle t): issue when count + inflight - pop < BUF_DEPTH, or REDIRECT = 1.
  - pop = IF_VALID & ~STALL.
  - On issue: MEM_RDEN1 = 1, MEM_ADDR1 = addr[15:2].
  - addr = REDIRECT ? {REDIRECT_PC[31:2],2'b00} : pc.
  - At the edge: pc <= addr + 4, inflight <= 1, tag <= addr.
  - No issue: MEM_RDEN1 = 0, pc unchanged, inflight <= 0.
- Response (cycle t+1): if inflight = 1 and REDIRECT = 0, push {MEM_DOUT1, tag} into the queue at the edge.
- Latency: issue t -> entry pushed at end of t+1 -> IF_VALID in t+2. First instruction after reset release is visible 2 cycles after the first issuing edge.
- Output: IF_IR/IF_PC/IF_PC_INC are combinational from the queue head; IF_VALID = (count != 0) & ~REDIRECT.
- Pop: head advances at the edge when IF_VALID & ~STALL. Push and pop in the same cycle are legal at any count, including full.
- Redirect:
  - Highest priority over STALL, push and pop.
  - Queue cleared (count = 0) and the cycle-t response discarded.
  - REDIRECT_PC issued in the same cycle; target visible at t+2 (1 bubble cycle after the redirect cycle).
- Redirect on consecutive cycles: the last one wins; each discards the prior issue.
- Full queue with STALL held: no issue, pc frozen, MEM_RDEN1 = 0; the queue never overflows (credit rule guarantees this).
- Empty queue with STALL: IF_VALID = 0; STALL has no effect.
- PC wraps modulo 2^32. MEM_ADDR1 uses pc[15:2] only; upper bits are carried in IF_PC unchanged.
- Queue is a circular buffer: rd/wr pointers are log2(BUF_DEPTH) bits and wrap naturally; count is log2(BUF_DEPTH)+1 bits.

Decomposition:
- otter_pkg (shared) holds:
  - opcode_t
  - NOP_INSTR = 32'h0000_0013
  - fetch_entry_t packed struct {ir[31:0], pc[31:0]}
  - RESET_PC default constant
- Sub-module fetch_queue:
  - Parameterised circular FIFO of fetch_entry_t.
  - Ports: push, pop, flush, din, dout, count.
  - Same async RST.
- otter_fetch_unit holds the PC/in-flight logic and the credit check.

Test Plan:
1. Reset release, STALL=0, memory word n = n: MEM_ADDR1 = 0,1,2,… every cycle; IF_VALID high from 2nd cycle after first issue; IF_PC = 0,4,8,…; IF_IR = 0,1,2,… one per cycle, none skipped.
2. Stream running, STALL held 5 cycles: IF_IR/IF_PC frozen on the head entry; queue fills to 2; MEM_RDEN1 drops to 0; on release, the sequence resumes with no gap and no duplicate.
3. REDIRECT=1, REDIRECT_PC=32'h0000_0100, queue holding 2 entries: IF_VALID = 0 in the redirect cycle and the following cycle; next IF_PC = 0x100, IF_IR = mem[0x40]; old entries and the in-flight response never appear.
4. REDIRECT together with STALL=1 and a full queue: queue flushed; 0x100 issued in the same cycle; the in-flight response discarded.
5. REDIRECT_PC = 32'h0000_0203: issue at word 0x80; IF_PC = 0x200.
6. RST asserted asynchronously mid-stream, between edges: IF_VALID = 0 and MEM_RDEN1 = 0 immediately; after release, the first IF_PC = RESET_PC and the pre-reset response is dropped.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: base opcodes, the canonical NOP, the fetch-queue
// entry layout and the default reset PC.
package otter_pkg;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpImm    = 7'b0010011,
    OpAuipc  = 7'b0010111,
    OpStore  = 7'b0100011,
    OpReg    = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111,
    OpSystem = 7'b1110011
  } opcode_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {instruction, pc} entries sitting between the
// instruction memory port and the IF/DE register.
//   clk, rst  : clock and asynchronous active-high reset
//   push/din  : write one entry at the tail
//   pop       : advance the head (ignored when empty)
//   flush     : drop every entry; wins over push and pop
//   dout      : head entry (reset contents are {NOP, RESET_PC})
//   count     : number of valid entries, 0..BUF_DEPTH
module fetch_queue
  import otter_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(BUF_DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam logic [PtrW:0] Full = (PtrW+1)'(BUF_DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  fetch_entry_t    buf_q [BUF_DEPTH];
  fetch_entry_t    buf_d [BUF_DEPTH];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop  = pop & (count_q != '0);
    // A push into a full queue is only accepted alongside a pop.
    do_push = push & ((count_q != Full) | do_pop);
    buf_d   = buf_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = wr_q;
      count_d = '0;
    end else begin
      if (do_push) begin
        buf_d[wr_q] = din;
        wr_d        = wr_q + PtrOne;
      end
      if (do_pop) begin
        rd_d = rd_q + PtrOne;
      end
      count_d = count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_q[i] <= '{ir: NOP_INSTR, pc: RESET_PC};
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign dout  = buf_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch front end. Owns the PC, issues 1-cycle synchronous
// reads on the instruction port, buffers responses so decode may stall, and
// flushes everything on a redirect.
//   CLK, RST           : clock, asynchronous active-high reset
//   STALL              : decode is not taking the head this cycle
//   REDIRECT/_PC       : restart fetch at REDIRECT_PC (bits [1:0] ignored)
//   MEM_ADDR1/RDEN1    : word address and read strobe to instruction memory
//   MEM_DOUT1          : read data, valid the cycle after the strobe
//   IF_VALID/IR/PC/INC : queue head presented to the IF/DE register
module otter_fetch_unit
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [13:0] MEM_ADDR1,
  output logic        MEM_RDEN1,
  input  logic [31:0] MEM_DOUT1,
  output logic        IF_VALID,
  output logic [31:0] IF_IR,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC_INC
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam logic [PtrW+1:0] DepthV = (PtrW+2)'(BUF_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   addr;
  logic          issue, pop, push;
  logic [PtrW:0] count;
  logic [PtrW+1:0] occ;
  fetch_entry_t  head, din;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  always_comb begin
    IF_VALID = (count != '0) & ~REDIRECT;
    pop      = IF_VALID & ~STALL;
    // Credit check: entries held plus the one in flight, less the one leaving,
    // must leave room for the response of a new issue.
    occ      = {1'b0, count} + {{(PtrW+1){1'b0}}, inflight_q}
             - {{(PtrW+1){1'b0}}, pop};
    issue    = ~RST & (REDIRECT | (occ < DepthV));
    addr     = REDIRECT ? {REDIRECT_PC[31:2], 2'b00} : pc_q;

    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (issue) begin
      pc_d  = addr + 32'd4;
      tag_d = addr;
    end

    // A response landing in a redirect cycle belongs to the old stream.
    push = inflight_q & ~REDIRECT;
    din  = '{ir: MEM_DOUT1, pc: tag_q};

    MEM_RDEN1 = issue;
    MEM_ADDR1 = addr[15:2];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(
    .BUF_DEPTH (BUF_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_fetch_queue (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .flush (REDIRECT),
    .din   (din),
    .dout  (head),
    .count (count)
  );

  assign IF_IR     = head.ir;
  assign IF_PC     = head.pc;
  assign IF_PC_INC = head.pc + 32'd4;

endmodule

// File: tb/tb_otter_fetch_unit.sv
module tb_otter_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        CLK, RST, STALL, REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [13:0] MEM_ADDR1;
  logic        MEM_RDEN1;
  logic [31:0] MEM_DOUT1;
  logic        IF_VALID;
  logic [31:0] IF_IR, IF_PC, IF_PC_INC;

  int n_checks = 0;
  int n_pass   = 0;

  otter_fetch_unit #(
    .RESET_PC  (RPC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .STALL       (STALL),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .MEM_ADDR1   (MEM_ADDR1),
    .MEM_RDEN1   (MEM_RDEN1),
    .MEM_DOUT1   (MEM_DOUT1),
    .IF_VALID    (IF_VALID),
    .IF_IR       (IF_IR),
    .IF_PC       (IF_PC),
    .IF_PC_INC   (IF_PC_INC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: synchronous read, data the cycle after the strobe.
  logic [31:0] mem [16384];
  always @(posedge CLK) if (MEM_RDEN1) MEM_DOUT1 <= mem[MEM_ADDR1];

  // Reference model: the fetch stream as a queue of fetched PCs plus one
  // outstanding request, advanced by the credit/redirect rules.
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_infl_pc, m_pc;
  bit          e_valid, e_pop, e_rden;
  logic [31:0] e_addr, e_pc, e_ir;

  task automatic model_eval();
    int occ;
    e_valid = (mq.size() != 0) && !REDIRECT;
    e_pop   = e_valid && !STALL;
    occ     = int'(mq.size()) + (m_infl ? 1 : 0) - (e_pop ? 1 : 0);
    e_rden  = REDIRECT || (occ < DEPTH);
    e_addr  = REDIRECT ? (REDIRECT_PC & 32'hFFFF_FFFC) : m_pc;
    e_pc    = e_valid ? mq[0] : RPC;
    e_ir    = mem[e_pc[15:2]];
  endtask

  task automatic model_tick();
    if (REDIRECT) begin
      mq.delete();
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_infl_pc);
    end
    m_infl = e_rden;
    if (e_rden) begin
      m_infl_pc = e_addr;
      m_pc      = e_addr + 32'd4;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl = 0;
    m_pc   = RPC;
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge.
  task automatic drive(input bit s, input bit r, input logic [31:0] rpc);
    STALL       = s;
    REDIRECT    = r;
    REDIRECT_PC = rpc;
    model_eval();
    @(negedge CLK);
  endtask

  task automatic tick();
    model_tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
    model_reset();
    @(posedge CLK);
    #2;
    n_checks++;
    if (IF_VALID !== 1'b0) $display("FAIL reset.valid: got %b want 0", IF_VALID);
    else n_pass++;
    n_checks++;
    if (MEM_RDEN1 !== 1'b0) $display("FAIL reset.rden: got %b want 0", MEM_RDEN1);
    else n_pass++;
    n_checks++;
    if ({IF_IR, IF_PC, IF_PC_INC} !== {32'h0000_0013, RPC, RPC + 32'd4})
      $display("FAIL reset.head: got ir=%h pc=%h inc=%h want 00000013 %h %h",
               IF_IR, IF_PC, IF_PC_INC, RPC, RPC + 32'd4);
    else n_pass++;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (IF_VALID !== e_valid) $display("FAIL stream.valid c%0d: got %b want %b", k, IF_VALID, e_valid);
      else n_pass++;
      n_checks++;
      if (MEM_RDEN1 !== 1'b1 || MEM_ADDR1 !== 14'(k))
        $display("FAIL stream.issue c%0d: got rden=%b addr=%h want 1 %h", k, MEM_RDEN1, MEM_ADDR1, k);
      else n_pass++;
      if (k >= 2) begin
        n_checks++;
        if (IF_VALID !== 1'b1 || IF_PC !== 32'(4 * (k - 2)) || IF_IR !== 32'(k - 2)
            || IF_PC_INC !== 32'(4 * (k - 1)))
          $display("FAIL stream.head c%0d: got v=%b pc=%h ir=%h inc=%h want 1 %h %h %h",
                   k, IF_VALID, IF_PC, IF_IR, IF_PC_INC, 4 * (k - 2), k - 2, 4 * (k - 1));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    for (int i = 0; i < 11; i++) begin
      drive(i < 5, 1'b0, 32'h0);
      if (i == 0) held = e_pc;
      n_checks++;
      if (IF_VALID !== e_valid || MEM_RDEN1 !== e_rden)
        $display("FAIL stall.ctl c%0d: got v=%b rden=%b want %b %b", i, IF_VALID, MEM_RDEN1, e_valid, e_rden);
      else n_pass++;
      n_checks++;
      if (i < 5 && (IF_PC !== held || IF_IR !== mem[held[15:2]] || MEM_RDEN1 !== 1'b0))
        $display("FAIL stall.hold c%0d: got pc=%h ir=%h rden=%b want %h %h 0",
                 i, IF_PC, IF_IR, MEM_RDEN1, held, mem[held[15:2]]);
      else if (i >= 5 && (IF_VALID !== 1'b1 || IF_PC !== held + 32'(4 * (i - 5))))
        $display("FAIL stall.resume c%0d: got v=%b pc=%h want 1 %h", i, IF_VALID, IF_PC, held + 32'(4 * (i - 5)));
      else n_pass++;
      tick();
    end
  endtask

  // Fill the queue with STALL, redirect to tgt (optionally still stalled),
  // then watch the bubble and the new stream.
  task automatic test_redirect(input bit stall_r, input logic [31:0] tgt, input string nm);
    logic [31:0] want_pc;
    want_pc = tgt & 32'hFFFF_FFFC;
    for (int i = 0; i < 9; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 32'h0);
      else if (i == 3) drive(stall_r, 1'b1, tgt);
      else drive(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (IF_VALID !== e_valid || MEM_RDEN1 !== e_rden || (e_rden && MEM_ADDR1 !== e_addr[15:2]))
        $display("FAIL %s.ctl c%0d: got v=%b rden=%b addr=%h want %b %b %h",
                 nm, i, IF_VALID, MEM_RDEN1, MEM_ADDR1, e_valid, e_rden, e_addr[15:2]);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (IF_VALID !== 1'b0 || MEM_RDEN1 !== 1'b1 || MEM_ADDR1 !== want_pc[15:2])
          $display("FAIL %s.issue: got v=%b rden=%b addr=%h want 0 1 %h",
                   nm, IF_VALID, MEM_RDEN1, MEM_ADDR1, want_pc[15:2]);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (IF_VALID !== 1'b0) $display("FAIL %s.bubble: got %b want 0", nm, IF_VALID);
        else n_pass++;
      end
      if (i >= 5) begin
        n_checks++;
        if (IF_VALID !== 1'b1 || IF_PC !== want_pc + 32'(4 * (i - 5))
            || IF_IR !== mem[want_pc[15:2] + 14'(i - 5)])
          $display("FAIL %s.target c%0d: got v=%b pc=%h ir=%h want 1 %h %h", nm, i, IF_VALID,
                   IF_PC, IF_IR, want_pc + 32'(4 * (i - 5)), mem[want_pc[15:2] + 14'(i - 5)]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      tick();
    end
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (IF_VALID !== 1'b0 || MEM_RDEN1 !== 1'b0 || IF_PC !== RPC)
      $display("FAIL rstmid.async: got v=%b rden=%b pc=%h want 0 0 %h", IF_VALID, MEM_RDEN1, IF_PC, RPC);
    else n_pass++;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (IF_VALID !== e_valid || (e_valid && (IF_PC !== e_pc || IF_IR !== e_ir)))
        $display("FAIL rstmid.run c%0d: got v=%b pc=%h ir=%h want %b %h %h",
                 i, IF_VALID, IF_PC, IF_IR, e_valid, e_pc, e_ir);
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (IF_VALID !== 1'b1 || IF_PC !== RPC)
          $display("FAIL rstmid.first: got v=%b pc=%h want 1 %h", IF_VALID, IF_PC, RPC);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    RST = 1'b1;
    STALL = 1'b0; REDIRECT = 1'b0;
    for (int a = 0; a < 16384; a++) mem[a] = $urandom;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, rpc);
      n_checks++;
      if (IF_VALID !== e_valid || MEM_RDEN1 !== e_rden || (e_rden && MEM_ADDR1 !== e_addr[15:2]))
        $display("FAIL random.ctl c%0d: got v=%b rden=%b addr=%h want %b %b %h",
                 i, IF_VALID, MEM_RDEN1, MEM_ADDR1, e_valid, e_rden, e_addr[15:2]);
      else n_pass++;
      if (e_valid) begin
        n_checks++;
        if (IF_PC !== e_pc || IF_IR !== e_ir || IF_PC_INC !== e_pc + 32'd4)
          $display("FAIL random.head c%0d: got pc=%h ir=%h inc=%h want %h %h %h",
                   i, IF_PC, IF_IR, IF_PC_INC, e_pc, e_ir, e_pc + 32'd4);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = 32'(a);
    test_reset();
    test_stream();
    test_stall();
    test_redirect(1'b0, 32'h0000_0100, "redir");
    test_redirect(1'b1, 32'h0000_0100, "redir_stall");
    test_redirect(1'b0, 32'h0000_0203, "redir_unaligned");
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
